// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory read-port arbiter: FSM state encoding and statistics width.
package mem_arb_pkg;
  typedef enum logic {IDLE, WAIT} arb_state_e;
  localparam int STAT_WIDTH = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the access-unit array, the arbiter and the memory controller.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_read_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_resp_o;
  logic [DATA_WIDTH-1:0]         req_rdata_o;
  logic                          mem_read_o;
  logic [ADDR_WIDTH-1:0]         mem_addr_o;
  logic                          mem_resp_i;
  logic [DATA_WIDTH-1:0]         mem_rdata_i;

  modport master (
    input  req_read_i, req_addr_i, mem_resp_i, mem_rdata_i,
    output req_resp_o, req_rdata_o, mem_read_o, mem_addr_o
  );

  modport slave (
    output req_read_i, req_addr_i, mem_resp_i, mem_rdata_i,
    input  req_resp_o, req_rdata_o, mem_read_o, mem_addr_o
  );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first eligible index searching upward from ptr+1, wrapping.
module rr_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);
  int cand;

  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = ID_WIDTH'(cand);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ level-protocol requesters.
// Optional per-requester saturating grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  mem_port_arbiter_if.master                          bus,
  output logic                                        busy_o,
  output logic [ID_WIDTH-1:0]                         grant_id_o,
  output logic [NUM_REQ*mem_arb_pkg::STAT_WIDTH-1:0]  grant_cnt_o
);
  import mem_arb_pkg::*;

  arb_state_e            state_q;
  logic [NUM_REQ-1:0]    mask_q;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   grant_id_q;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  resp_fire;

  assign eligible  = bus.req_read_i & ~mask_q;
  assign grant_oh  = NUM_REQ'(1) << grant_id_q;
  assign resp_fire = (state_q == WAIT) && bus.mem_resp_i;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // The mask only lives for one IDLE cycle: long enough to hide the just-served
  // requester's registered read deassertion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
      mask_q     <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mask_q <= '0;
          if (pick_found) begin
            grant_id_q <= pick_idx;
            ptr_q      <= pick_idx;
            addr_q     <= bus.req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_i) begin
            mask_q  <= grant_oh;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_read_o  = (state_q == WAIT);
  assign bus.mem_addr_o  = addr_q;
  assign bus.req_resp_o  = resp_fire ? grant_oh : '0;
  assign bus.req_rdata_o = resp_fire ? bus.mem_rdata_i : '0;
  assign busy_o          = (state_q == WAIT);
  assign grant_id_o      = grant_id_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_q == IDLE && pick_found && cnt_q[pick_idx] != '1) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt_o[g*STAT_WIDTH +: STAT_WIDTH] = cnt_q[g];
  end
`else
  assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         busy;
  logic [1:0]   gid;
  logic [127:0] gcnt;
  int           n_checks = 0;
  int           n_fail   = 0;

  mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_o      (busy),
    .grant_id_o  (gid),
    .grant_cnt_o (gcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic        mresp;
    logic        emr;
    logic [63:0] eaddr;
    logic [3:0]  eresp;
    logic [1:0]  egid;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t v(logic [3:0] rd, logic mresp, logic emr, logic [63:0] eaddr,
                             logic [3:0] eresp, logic [1:0] egid);
    vec_t r;
    r.rd = rd; r.mresp = mresp; r.emr = emr; r.eaddr = eaddr; r.eresp = eresp; r.egid = egid;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs();
    bus.req_addr_i = {64'h80, 64'h40, 64'h20, 64'h10};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_read_i  = '0;
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    set_addrs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One full transaction for requester id, bounded wait for the grant.
  task automatic run_txn(input int id);
    int k;
    k = 0;
    bus.req_read_i = 4'b0001 << id;
    while (!busy && k < 8) begin
      step();
      k++;
    end
    check($sformatf("txn%0d granted", id), {63'd0, busy}, 64'd1);
    check($sformatf("txn%0d grant id", id), {62'd0, gid}, id);
    bus.mem_resp_i = 1'b1;
    step();
    bus.mem_resp_i = 1'b0;
    bus.req_read_i = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] data;

    // Rows 0-9: all four contend, 10-16: requester 2 alone with slow memory then a
    // spurious response, 17-23: requester 1 re-requests straight after its response.
    tbl[0]  = v(4'hF, 0, 0, 64'h0,  4'h0, 2'd0);
    tbl[1]  = v(4'hF, 1, 1, 64'h10, 4'h1, 2'd0);
    tbl[2]  = v(4'hF, 0, 0, 64'h0,  4'h0, 2'd0);
    tbl[3]  = v(4'hF, 1, 1, 64'h20, 4'h2, 2'd1);
    tbl[4]  = v(4'hF, 0, 0, 64'h0,  4'h0, 2'd1);
    tbl[5]  = v(4'hF, 1, 1, 64'h40, 4'h4, 2'd2);
    tbl[6]  = v(4'hF, 0, 0, 64'h0,  4'h0, 2'd2);
    tbl[7]  = v(4'hF, 1, 1, 64'h80, 4'h8, 2'd3);
    tbl[8]  = v(4'hF, 0, 0, 64'h0,  4'h0, 2'd3);
    tbl[9]  = v(4'hF, 1, 1, 64'h10, 4'h1, 2'd0);
    tbl[10] = v(4'h4, 0, 0, 64'h0,  4'h0, 2'd0);
    tbl[11] = v(4'h4, 0, 1, 64'h40, 4'h0, 2'd2);
    tbl[12] = v(4'h4, 0, 1, 64'h40, 4'h0, 2'd2);
    tbl[13] = v(4'h4, 0, 1, 64'h40, 4'h0, 2'd2);
    tbl[14] = v(4'h4, 1, 1, 64'h40, 4'h4, 2'd2);
    tbl[15] = v(4'h0, 0, 0, 64'h0,  4'h0, 2'd2);
    tbl[16] = v(4'h0, 1, 0, 64'h0,  4'h0, 2'd2);
    tbl[17] = v(4'h2, 0, 0, 64'h0,  4'h0, 2'd2);
    tbl[18] = v(4'h2, 1, 1, 64'h20, 4'h2, 2'd1);
    tbl[19] = v(4'h2, 0, 0, 64'h0,  4'h0, 2'd1);
    tbl[20] = v(4'h2, 0, 0, 64'h0,  4'h0, 2'd1);
    tbl[21] = v(4'h2, 0, 1, 64'h20, 4'h0, 2'd1);
    tbl[22] = v(4'h2, 1, 1, 64'h20, 4'h2, 2'd1);
    tbl[23] = v(4'h0, 0, 0, 64'h0,  4'h0, 2'd1);

    do_reset();
    #3;
    check("reset mem_read", {63'd0, bus.mem_read_o}, 64'd0);
    check("reset mem_addr", bus.mem_addr_o, 64'd0);
    check("reset req_resp", {60'd0, bus.req_resp_o}, 64'd0);
    check("reset req_rdata", bus.req_rdata_o, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset grant_id", {62'd0, gid}, 64'd0);
    check("reset cnt lo", gcnt[63:0], 64'd0);
    check("reset cnt hi", gcnt[127:64], 64'd0);
    step();

    for (int i = 0; i < 24; i++) begin
      bus.req_read_i  = tbl[i].rd;
      bus.mem_resp_i  = tbl[i].mresp;
      bus.mem_rdata_i = 64'hDA7A_0000 + 64'(i);
      #4;
      data = (tbl[i].eresp != 4'h0) ? 64'hDA7A_0000 + 64'(i) : 64'h0;
      check($sformatf("row%0d mem_read", i), {63'd0, bus.mem_read_o}, {63'd0, tbl[i].emr});
      check($sformatf("row%0d busy", i), {63'd0, busy}, {63'd0, tbl[i].emr});
      check($sformatf("row%0d grant_id", i), {62'd0, gid}, {62'd0, tbl[i].egid});
      check($sformatf("row%0d req_resp", i), {60'd0, bus.req_resp_o}, {60'd0, tbl[i].eresp});
      check($sformatf("row%0d req_rdata", i), bus.req_rdata_o, data);
      if (tbl[i].emr)
        check($sformatf("row%0d mem_addr", i), bus.mem_addr_o, tbl[i].eaddr);
      @(posedge clk);
      #1;
    end
    bus.mem_resp_i = 1'b0;

    // Address change and read drop during WAIT must not disturb the transaction.
    bus.req_read_i = 4'b1000;
    step();
    check("chg busy", {63'd0, busy}, 64'd1);
    check("chg addr at grant", bus.mem_addr_o, 64'h80);
    bus.req_addr_i[3*64 +: 64] = 64'hABC;
    bus.req_read_i = 4'b0000;
    step();
    check("chg addr held", bus.mem_addr_o, 64'h80);
    check("chg no early resp", {60'd0, bus.req_resp_o}, 64'd0);
    check("chg still busy", {63'd0, busy}, 64'd1);
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("chg resp after drop", {60'd0, bus.req_resp_o}, 64'h8);
    check("chg rdata", bus.req_rdata_o, 64'h1234_5678_9ABC_DEF0);
    step();
    bus.mem_resp_i = 1'b0;
    check("chg idle after resp", {63'd0, busy}, 64'd0);
    set_addrs();
    step();

    // Reset in the middle of WAIT aborts silently; requester 0 then wins first.
    bus.req_read_i = 4'b0010;
    step();
    check("rstw busy before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    step();
    check("rstw mem_read", {63'd0, bus.mem_read_o}, 64'd0);
    check("rstw busy", {63'd0, busy}, 64'd0);
    check("rstw resp", {60'd0, bus.req_resp_o}, 64'd0);
    rst = 1'b0;
    bus.req_read_i = 4'b0011;
    step();
    check("rstw regrant busy", {63'd0, busy}, 64'd1);
    check("rstw regrant id", {62'd0, gid}, 64'd0);
    check("rstw regrant addr", bus.mem_addr_o, 64'h10);
    bus.mem_resp_i = 1'b1;
    #1;
    check("rstw regrant resp", {60'd0, bus.req_resp_o}, 64'h1);
    step();
    bus.mem_resp_i = 1'b0;
    bus.req_read_i = '0;
    step();

    // Grant statistics.
    do_reset();
    for (int n = 0; n < 5; n++) run_txn(3);
    for (int n = 0; n < 2; n++) run_txn(0);
`ifdef MEM_ARB_STATS_EN
    check("cnt req3", gcnt[3*32 +: 32], 64'd5);
    check("cnt req0", gcnt[0 +: 32], 64'd2);
    check("cnt req1", gcnt[1*32 +: 32], 64'd0);
    dut.cnt_q[3] = 32'hFFFF_FFFE;
    run_txn(3);
    check("cnt req3 near sat", gcnt[3*32 +: 32], 64'hFFFF_FFFF);
    run_txn(3);
    check("cnt req3 saturated", gcnt[3*32 +: 32], 64'hFFFF_FFFF);
`else
    check("cnt tied lo", gcnt[63:0], 64'd0);
    check("cnt tied hi", gcnt[127:64], 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
